// File: rtl/cpu_clock_ctrl_if.sv
// Signal bundle between the run/halt controller and its surroundings:
// prescaler tick, board buttons, and the core-side enable/halt/status lines.
interface cpu_clock_ctrl_if;
  logic        tick_in;
  logic        btn_run;
  logic        btn_step;
  logic        halt_req;
  logic        cpu_en;
  logic        running;
  logic [15:0] cycle_cnt;

  modport master (
    output tick_in, btn_run, btn_step, halt_req,
    input  cpu_en, running, cycle_cnt
  );

  modport slave (
    input  tick_in, btn_run, btn_step, halt_req,
    output cpu_en, running, cycle_cnt
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step controller: debounces RUN/STEP buttons, gates the
// prescaler tick into a one-cycle CPU enable and counts issued CPU cycles.
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic           clk,
  input  logic           reset,
  cpu_clock_ctrl_if.slave bus
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2 ** CNT_W) begin : g_bad_params
    $error("cpu_clock_ctrl: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  localparam logic [1:0] HALT      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] STEP_WAIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  logic [1:0]       btn_raw;
  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       deb;
  logic [1:0]       press;
  logic [CNT_W-1:0] deb_cnt [2];

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        cpu_en_c;
  logic [15:0] cycle_cnt_q;

  logic run_press;
  logic step_press;

  assign btn_raw    = {bus.btn_step, bus.btn_run};
  assign run_press  = press[BTN_RUN];
  assign step_press = press[BTN_STEP];

  // Both buttons share one synchroniser/debounce structure, indexed by button.
  // press[] is a registered one-cycle pulse raised only on a debounced 0->1 change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      press  <= '0;
      // NOTE: the counter array is only two entries of flops, so it is reset
      // like any other state; large RAM-style arrays would be left unreset.
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two sync stages as distinct
      // flops; a blocking '=' here would collapse them into one.
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
          press[i]   <= sync_b[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // cpu_en is decoded combinationally so it lines up with the tick itself.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_nxt = state;
    cpu_en_c  = 1'b0;
    case (state)
      HALT: begin
        if (!bus.halt_req) begin
          if (run_press)       state_nxt = RUN;
          else if (step_press) state_nxt = STEP_WAIT;
        end
      end
      RUN: begin
        cpu_en_c = bus.tick_in & ~bus.halt_req;
        if (bus.halt_req || run_press) state_nxt = HALT;
      end
      STEP_WAIT: begin
        cpu_en_c = bus.tick_in & ~bus.halt_req;
        if (bus.halt_req || bus.tick_in) state_nxt = HALT;
      end
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HALT;
      cycle_cnt_q <= '0;
    end else begin
      state       <= state_nxt;
      cycle_cnt_q <= cycle_cnt_q + {15'd0, cpu_en_c};
    end
  end

  assign bus.cpu_en    = cpu_en_c;
  assign bus.running   = (state == RUN);
  assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Run/halt/single-step controller that sits between the CPU clock prescaler and the 4-bit CPU core. It consumes the prescaler's one-cycle tick and produces the CPU clock-enable pulse. It synchronises and debounces the board RUN and STEP push-buttons, honours a halt request from the core (HLT decode), and counts executed CPU cycles for the display.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised button level must hold before the debounced level changes (minimum 2)
CNT_W, 20, width of each debounce counter (must hold DEBOUNCE_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
tick_in  input  1  one-clk-cycle pulse from the clock prescaler
btn_run  input  1  raw RUN button, active-high, asynchronous
btn_step  input  1  raw STEP button, active-high, asynchronous
halt_req  input  1  level from core, 1 = stop issuing CPU cycles
cpu_en  output  1  one-clk-cycle CPU clock enable
running  output  1  1 while in RUN state
cycle_cnt  output  16  number of cpu_en pulses issued, wraps

Behaviour:
- Reset (reset==0, async): state=HALT; sync flops, debounced levels, debounce counters and cycle_cnt are all 0. cpu_en=0, running=0. Reset mid-operation aborts any pending step; no cpu_en is issued during reset.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter clears whenever the synced level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while levels still differ, the debounced level takes the synced level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
  - Press event = one-cycle pulse on a debounced 0->1 edge. Release produces no event.
  - Latency from a clean raw edge to the press event: 2 sync cycles + DEBOUNCE_CYCLES + 1 clk.
- FSM (state registered; cpu_en combinational from state and tick_in, zero latency from tick_in):
  - HALT:
    - cpu_en=0.
    - run_press and !halt_req -> RUN.
    - Else step_press and !halt_req -> STEP_WAIT.
    - All presses are ignored while halt_req=1.
    - If run_press and step_press occur in the same cycle, run wins.
  - RUN:
    - cpu_en = tick_in & !halt_req.
    - halt_req=1 -> HALT, and cpu_en is suppressed in that same cycle.
    - run_press -> HALT; a tick in that same cycle still passes, so cpu_en=1.
    - step_press is ignored.
  - STEP_WAIT:
    - Waits for the next tick_in.
    - On tick_in & !halt_req: cpu_en=1 for that cycle, then -> HALT. Exactly one pulse per step.
    - halt_req=1 -> HALT with no pulse.
    - run_press and step_press are ignored; the step completes first.
- running = (state==RUN), registered with the state.
- cycle_cnt increments by 1 in the cycle after each cpu_en=1 and wraps 0xFFFF -> 0x0000.
- A tick_in held high for several cycles (out of contract) yields cpu_en on each cycle in RUN, and only the first cycle in STEP_WAIT.

Test Plan:
1. DEBOUNCE_CYCLES=4, tick_in every 5 clks; reset low then high; press btn_run cleanly -> running=1 within 2+4+1 clks; cpu_en pulses exactly on tick cycles; cycle_cnt=10 after 10 ticks.
2. From HALT, press btn_step once; tick arrives 7 clks later -> exactly one cpu_en on that tick; state HALT; cycle_cnt +1; subsequent ticks produce no cpu_en.
3. btn_run glitch high for 3 clks (DEBOUNCE_CYCLES=4) -> no press event; running stays 0. Bouncing 1-0-1 then stable 10 clks -> exactly one RUN transition.
4. In RUN, assert halt_req in the same cycle as tick_in -> cpu_en=0, running=0 next cycle. Press run while halt_req=1 -> stays HALT. Deassert and press run -> RUN.
5. Preload cycle_cnt near wrap by running 65535 ticks, then one more tick -> cycle_cnt=0x0000; next tick -> 0x0001.
6. STEP_WAIT pending, drive reset=0 asynchronously before tick -> cpu_en=0, state HALT, cycle_cnt=0; after release, ticks produce no cpu_en.
